// File: rtl/image_tx_serializer.sv
// image_tx_serializer: clock-master bit-serial image transmitter with sync header and checksum trailer
module image_tx_serializer #(
  parameter int LENGTH = 28,
  parameter int WIDTH = 28,
  parameter int CLK_DIV = 1000,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic fpga_clk,
  input  logic rst,
  input  logic start,
  input  logic [LENGTH*WIDTH-1:0] image,
  output logic tx_clk,
  output logic tx_data,
  output logic tx_en,
  output logic busy,
  output logic done
);
  localparam int P = LENGTH * WIDTH;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(P + 1) > 3 ? $clog2(P + 1) : 3;
  localparam logic [2:0] IDLE = 3'd0, HEADER = 3'd1, PAYLOAD = 3'd2, TRAILER = 3'd3, FINISH = 3'd4;
  logic [2:0] state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [P-1:0] sh_q, sh_d;
  logic [7:0] csum_q, csum_d;
  logic clk_q, clk_d, data_q, data_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic wrap, fall, last;
  assign wrap = div_q == DW'(CLK_DIV - 1);
  assign fall = wrap && clk_q;
  assign cnt_n = cnt_q + 1'b1;
  assign last = cnt_q == (state_q == PAYLOAD ? CW'(P - 1) : CW'(7));
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    csum_d = csum_q;
    clk_d = clk_q;
    data_d = data_q;
    en_d = en_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (state_q == IDLE || state_q == FINISH) begin
      {clk_d, data_d, en_d, busy_d} = '0;
      state_d = IDLE;
      if (start) begin
        state_d = HEADER;
        div_d = '0;
        cnt_d = '0;
        sh_d = image;
        csum_d = '0;
        data_d = SYNC[0];
        en_d = 1'b1;
        busy_d = 1'b1;
      end
    end else begin
      div_d = wrap ? '0 : div_q + 1'b1;
      clk_d = clk_q ^ wrap;
      if (fall && state_q == TRAILER && last) begin
        state_d = FINISH;
        {clk_d, data_d, en_d, busy_d} = '0;
        done_d = 1'b1;
      end else if (fall) begin
        cnt_d = last ? '0 : cnt_n;
        state_d = last ? (state_q == HEADER ? PAYLOAD : TRAILER) : state_q;
        if ((state_q == HEADER && last) || (state_q == PAYLOAD && !last)) begin
          data_d = sh_q[0];
          sh_d = sh_q >> 1;
          csum_d = csum_q + {7'd0, sh_q[0]};
        end else
          data_d = state_q == HEADER ? SYNC[cnt_n[2:0]] : csum_q[last ? 3'd0 : cnt_n[2:0]];
      end
    end
  end
  always_ff @(posedge fpga_clk)
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      csum_q <= '0;
      clk_q <= 1'b0;
      data_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      csum_q <= csum_d;
      clk_q <= clk_d;
      data_q <= data_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign tx_clk = clk_q;
  assign tx_data = data_q;
  assign tx_en = en_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_image_tx_serializer.sv
// tb_image_tx_serializer: frame-level model and directed scenarios for image_tx_serializer
module tb_image_tx_serializer;
  localparam int L = 2, W = 3, CD = 2, P = L * W, N = 16 + P, FR = N * 2 * CD;
  localparam int BP = 784, BN = 16 + BP, BFR = BN * 2;
  logic clk = 0, rst = 1, start = 0;
  logic [P-1:0] image = '0;
  logic brst = 1, bstart = 0;
  logic [BP-1:0] bimage = '1;
  logic tx_clk, tx_data, tx_en, busy, done;
  logic b_clk, b_data, b_en, b_busy, b_done;
  logic [7:0] sync = 8'hA5;
  int compared = 0, mism = 0;
  always #5 clk = ~clk;
  image_tx_serializer #(.LENGTH(L), .WIDTH(W), .CLK_DIV(CD)) dut (
    .fpga_clk(clk), .rst(rst), .start(start), .image(image),
    .tx_clk(tx_clk), .tx_data(tx_data), .tx_en(tx_en), .busy(busy), .done(done));
  image_tx_serializer #(.CLK_DIV(1)) big (
    .fpga_clk(clk), .rst(brst), .start(bstart), .image(bimage),
    .tx_clk(b_clk), .tx_data(b_data), .tx_en(b_en), .busy(b_busy), .done(b_done));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  int k = -1;
  logic bits[$];
  logic ec, ed, ee, edn;
  always @(posedge clk) begin
    if (rst) k = -1;
    else if ((k == -1 || k == FR) && start) begin
      logic [7:0] cs;
      bits = {};
      cs = 8'd0;
      for (int i = 0; i < 8; i++) bits.push_back(sync[i]);
      for (int i = 0; i < P; i++) begin bits.push_back(image[i]); cs = cs + {7'd0, image[i]}; end
      for (int i = 0; i < 8; i++) bits.push_back(cs[i]);
      k = 0;
    end else if (k == FR) k = -1;
    else if (k >= 0) k++;
    #1;
    ee = k >= 0 && k < FR;
    ec = ee && (k % (2 * CD)) >= CD;
    ed = ee ? bits[k / (2 * CD)] : 1'b0;
    edn = k == FR;
    chk("tx_clk", tx_clk, ec);
    chk("tx_data", tx_data, ed);
    chk("tx_en", tx_en, ee);
    chk("busy", busy, ee);
    chk("done", done, edn);
  end
  int bk = -1;
  logic bbits[$];
  logic bec, bed, bee, bedn;
  always @(posedge clk) begin
    if (brst) bk = -1;
    else if ((bk == -1 || bk == BFR) && bstart) begin
      logic [7:0] cs;
      bbits = {};
      cs = 8'd0;
      for (int i = 0; i < 8; i++) bbits.push_back(sync[i]);
      for (int i = 0; i < BP; i++) begin bbits.push_back(bimage[i]); cs = cs + {7'd0, bimage[i]}; end
      for (int i = 0; i < 8; i++) bbits.push_back(cs[i]);
      bk = 0;
    end else if (bk == BFR) bk = -1;
    else if (bk >= 0) bk++;
    #1;
    bee = bk >= 0 && bk < BFR;
    bec = bee && (bk % 2) == 1;
    bed = bee ? bbits[bk / 2] : 1'b0;
    bedn = bk == BFR;
    chk("b_tx_clk", b_clk, bec);
    chk("b_tx_data", b_data, bed);
    chk("b_tx_en", b_en, bee);
    chk("b_busy", b_busy, bee);
    chk("b_done", b_done, bedn);
  end
  logic pc = 0;
  logic [21:0] cap = '0;
  int ncap = 0;
  always @(posedge clk) begin
    #1;
    if (tx_clk && !pc) begin cap = {tx_data, cap[21:1]}; ncap++; end
    pc = tx_clk;
  end
  logic bpc = 0, bpd = 0, bpe = 0;
  logic [7:0] bcap = '0;
  int bn = 0, bviol = 0;
  always @(posedge clk) begin
    #1;
    if (b_clk && !bpc) begin bcap = {b_data, bcap[7:1]}; bn++; end
    if (b_en && bpe && b_data != bpd && !(bpc && !b_clk)) bviol++;
    bpc = b_clk;
    bpd = b_data;
    bpe = b_en;
  end
  task automatic run_frame(input logic [5:0] img, input string nm, output int n);
    int base;
    image = img;
    start = 1;
    base = ncap;
    @(negedge clk);
    start = 0;
    chk({nm, "_en_t1"}, tx_en, 1);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_done_at"}, n, 88);
    chk({nm, "_nbits"}, ncap - base, 22);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int n, base, nb, nd, dc;
    repeat (3) @(negedge clk);
    rst = 0;
    brst = 0;
    chk("rst_outs", {tx_clk, tx_data, tx_en, busy, done}, 0);
    chk("b_rst_outs", {b_clk, b_data, b_en, b_busy, b_done}, 0);
    run_frame(6'b101101, "s1", n);
    chk("s1_bits", cap, {8'h04, 6'b101101, 8'hA5});
    @(negedge clk);
    chk("s1_idle_outs", {tx_clk, tx_data, tx_en, busy, done}, 0);
    repeat (3) @(negedge clk);
    run_frame(6'b000000, "s2a", n);
    chk("s2a_bits", cap, {8'h00, 6'b000000, 8'hA5});
    chk("s2_gap_en", tx_en, 0);
    run_frame(6'b111111, "s2b", n);
    chk("s2b_bits", cap, {8'h06, 6'b111111, 8'hA5});
    repeat (3) @(negedge clk);
    image = 6'b010011;
    start = 1;
    base = ncap;
    nb = 0;
    nd = 0;
    dc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 10) start = 0;
      if (c == 40) start = 1;
      if (c == 41) start = 0;
      if (c < 89 && !busy) nb++;
      if (done) begin nd++; dc = c; end
    end
    chk("s3_busy_gaps", nb, 0);
    chk("s3_done_count", nd, 1);
    chk("s3_done_at", dc, 89);
    chk("s3_nbits", ncap - base, 22);
    chk("s3_bits", cap, {8'h03, 6'b010011, 8'hA5});
    image = 6'b110100;
    start = 1;
    base = ncap;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 200) begin image = ~image; @(negedge clk); n++; end
    chk("s4_done_at", n, 88);
    chk("s4_bits", cap, {8'h03, 6'b110100, 8'hA5});
    @(negedge clk);
    image = 6'b100001;
    start = 1;
    for (int c = 1; c <= 49; c++) begin @(negedge clk); start = 0; end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("s5_rst_outs", {tx_clk, tx_data, tx_en, busy, done}, 0);
    nd = 0;
    repeat (100) begin @(negedge clk); if (done || busy) nd++; end
    chk("s5_no_done", nd, 0);
    run_frame(6'b011110, "s5", n);
    chk("s5_bits", cap, {8'h04, 6'b011110, 8'hA5});
    base = bn;
    bstart = 1;
    @(negedge clk);
    bstart = 0;
    chk("b_en_t1", b_en, 1);
    n = 0;
    while (!b_done && n < 4000) begin @(negedge clk); n++; end
    chk("b_frame_len", n, 1600);
    chk("b_nbits", bn - base, 800);
    chk("b_csum", bcap, 8'h10);
    chk("b_edge_viol", bviol, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
